// File: rtl/char_ram_write_arbiter.sv
// Write-port arbiter for the character/attribute RAM: CPU single-byte writes
// share the port round-robin with a region fill engine; all outputs registered.
module char_ram_write_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpuRequest,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0] cpuData,
  output logic                  cpuAcknowledge,
  input  logic                  fillStart,
  input  logic [ADDR_WIDTH-1:0] fillBase,
  input  logic [ADDR_WIDTH:0]   fillLength,
  input  logic [DATA_WIDTH-1:0] fillValue,
  output logic                  fillBusy,
  output logic                  fillDone,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramData,
  output logic                  ramWriteEnable
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_FILL = 1'b1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  fill_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fill_addr_reg, fill_addr_next;
  logic [ADDR_WIDTH:0]   fill_count_reg, fill_count_next;
  logic [DATA_WIDTH-1:0] fill_value_reg, fill_value_next;
  logic                  last_grant_reg, last_grant_next;

  logic                  ram_we_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_data_reg;
  logic                  cpu_ack_reg;
  logic                  fill_busy_reg;
  logic                  fill_done_reg;

  logic cpu_eligible, fill_eligible;
  logic grant_cpu, grant_fill;

  // The CPU is ineligible during its ack cycle: its request is still high then.
  assign cpu_eligible  = cpuRequest && !cpu_ack_reg;
  assign fill_eligible = (state_reg == RUN);

  always_comb begin
    grant_cpu       = cpu_eligible;
    grant_fill      = fill_eligible;
    last_grant_next = last_grant_reg;
    if (cpu_eligible && fill_eligible) begin
      grant_cpu       = (last_grant_reg == GRANT_FILL);
      grant_fill      = !grant_cpu;
      last_grant_next = grant_cpu ? GRANT_CPU : GRANT_FILL;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fill_addr_next  = fill_addr_reg;
    fill_count_next = fill_count_reg;
    fill_value_next = fill_value_reg;
    case (state_reg)
      IDLE: begin
        if (fillStart) begin
          fill_addr_next  = fillBase;
          fill_value_next = fillValue;
          fill_count_next = (fillLength > MAX_LEN) ? MAX_LEN : fillLength;
          state_next      = (fillLength == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (grant_fill) begin
          fill_addr_next  = fill_addr_reg + 1'b1;
          fill_count_next = fill_count_reg - 1'b1;
          if (fill_count_reg == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      fill_addr_reg  <= '0;
      fill_count_reg <= '0;
      fill_value_reg <= '0;
      last_grant_reg <= GRANT_FILL;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      cpu_ack_reg    <= 1'b0;
      fill_busy_reg  <= 1'b0;
      fill_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fill_addr_reg  <= fill_addr_next;
      fill_count_reg <= fill_count_next;
      fill_value_reg <= fill_value_next;
      last_grant_reg <= last_grant_next;
      ram_we_reg     <= grant_cpu || grant_fill;
      cpu_ack_reg    <= grant_cpu;
      if (grant_cpu) begin
        ram_addr_reg <= cpuAddress;
        ram_data_reg <= cpuData;
      end else if (grant_fill) begin
        ram_addr_reg <= fill_addr_reg;
        ram_data_reg <= fill_value_reg;
      end
      // Busy/done lag the FSM by one register so they line up with the writes.
      fill_busy_reg  <= (state_reg == RUN);
      fill_done_reg  <= (state_reg == DONE);
    end
  end

  assign ramWriteEnable = ram_we_reg;
  assign ramAddress     = ram_addr_reg;
  assign ramData        = ram_data_reg;
  assign cpuAcknowledge = cpu_ack_reg;
  assign fillBusy       = fill_busy_reg;
  assign fillDone       = fill_done_reg;

endmodule

// File: doc/char_ram_write_arbiter.md
Name: char_ram_write_arbiter

Overview:
- Shares the single write port of the 4096 x 8 character/attribute RAM in the HDMI 720p path between two requesters.
- Requester 1: CPU single-byte writes, from the custom-instruction or bus side.
- Requester 2: an internal fill engine that clears or fills a contiguous region, such as a screen clear or line blank, with one byte value.
- Sits in the write-clock domain and drives the RAM write-side address, data and write-enable directly. The read side remains with the pixel pipeline.

Parameters:
- ADDR_WIDTH, 12, RAM address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clock  input  1  system clock; the RAM write clock is driven from the same net.
- reset  input  1  synchronous, active-high reset.
- cpuRequest  input  1  CPU write request; level, held until acknowledged.
- cpuAddress  input  ADDR_WIDTH  CPU write address; must be stable while cpuRequest is high.
- cpuData  input  DATA_WIDTH  CPU write data; must be stable while cpuRequest is high.
- cpuAcknowledge  output  1  one-cycle pulse, coincident with the CPU write on the RAM port.
- fillStart  input  1  one-cycle pulse that starts a fill.
- fillBase  input  ADDR_WIDTH  first fill address; sampled with fillStart.
- fillLength  input  ADDR_WIDTH+1  number of bytes, 0..4096; sampled with fillStart.
- fillValue  input  DATA_WIDTH  fill byte; sampled with fillStart.
- fillBusy  output  1  high while a fill is in progress.
- fillDone  output  1  one-cycle pulse when a fill completes.
- ramAddress  output  ADDR_WIDTH  connects to RAM address1.
- ramData  output  DATA_WIDTH  connects to RAM dataIn1.
- ramWriteEnable  output  1  connects to RAM writeEnable.

Behaviour:
- All outputs are registered.
- Reset values: ramWriteEnable=0, ramAddress=0, ramData=0, cpuAcknowledge=0, fillBusy=0, fillDone=0. Fill FSM goes to IDLE; round-robin pointer lastGrant is set to FILL, so the CPU wins the first contention.
- Fill FSM states:
  - IDLE: fillStart latches base, length and value.
    - fillLength=0 -> go to DONE.
    - Otherwise -> go to RUN, and set fillBusy=1 from the next cycle.
    - Length values above 4096 are clamped to 4096.
  - RUN: each fill grant issues one write at the current address, increments the address modulo 2**ADDR_WIDTH (0xFFF wraps to 0x000), and decrements the remaining count. When the last write is issued -> go to DONE.
  - DONE: fillDone=1 and fillBusy=0 for exactly one cycle, then -> IDLE.
  - fillStart is ignored in RUN and in DONE; no queueing.
- CPU eligibility: eligible when cpuRequest=1 and cpuAcknowledge=0. The requester sees the ack and drops the request by the next edge; this rule prevents a double write.
- Arbitration, evaluated each cycle:
  - Only one requester eligible (CPU eligible, or fill in RUN): that requester is granted.
  - Both eligible: the requester opposite to lastGrant is granted.
  - lastGrant updates only on contended grants.
- Grant timing: a grant at edge N drives ramWriteEnable=1 with that requester's address and data during cycle N..N+1. A CPU grant also pulses cpuAcknowledge in that same cycle.
- With no grant, ramWriteEnable=0. Address and data hold their last values.
- Latency:
  - CPU: request seen at edge N with no contention -> write and ack in the following cycle (1 cycle).
  - Fill alone with length L: start at edge 0 -> writes in cycles 1..L -> fillDone in cycle L+1.
- Reset mid-fill: the fill aborts with no fillDone pulse and no further writes. A pending CPU request is not acknowledged and must be held by the requester.
- fillStart and cpuRequest in the same cycle: the CPU is granted immediately, since the fill is not yet in RUN.

Test Plan:
- Reset, then CPU write addr=0x123 data=0x5A -> ramWriteEnable=1, ramAddress=0x123, ramData=0x5A, cpuAcknowledge=1 for exactly one cycle, one cycle after the request. No second write while the request is held through the ack cycle.
- fillStart base=0x010 len=3 val=0x20 -> writes to 0x010, 0x011, 0x012 in three consecutive cycles. fillDone pulses one cycle after the last write, and fillBusy falls at the same time.
- Wrap-around: base=0xFFE len=4 val=0xFF -> write addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Contention: fill len=6 running while the CPU holds back-to-back requests -> writes alternate CPU/fill at most every cycle, and the CPU gets the first contended slot after reset. All six fill bytes land at the correct addresses, and fillDone follows the sixth fill write.
- len=0 -> fillDone one cycle after start with no writes. len=4096 at base 0x800 -> exactly 4096 writes covering all addresses once.
- Assert reset during a fill after 2 of 10 writes -> no further writes, no fillDone, all outputs at reset values. A new fillStart afterwards is accepted normally.
